// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
// Fetch-stage instruction queue: issues in-order imem requests at PCF, buffers
// returned words with their PCs, hands them to decode and drops in-flight work on FlushD.
module fetch_queue #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        StallF,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        ValidD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    // One extra bit: back-to-back flushes can stack drops beyond DEPTH.
    localparam int unsigned DW = CW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [AW-1:0]    fptr_q, fptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    pend_q, pend_d;
    logic [DW-1:0]    drop_q, drop_d;
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      pc_d    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      instr_d [DEPTH];

    logic pop_c;
    logic alloc_c;
    logic fill_c;
    logic discard_c;

    // Handshakes and head-of-queue presentation
    always_comb begin
        ValidD         = filled_q[head_q];
        pop_c          = ValidD & ~StallD & ~FlushD;
        imem_req_valid = ~rst & ~FlushD & ((count_q < CW'(DEPTH)) | pop_c);
        imem_req_addr  = PCF;
        alloc_c        = imem_req_valid & imem_req_ready;
        StallF         = rst | (~FlushD & ~alloc_c);
        fill_c         = imem_rsp_valid & ~FlushD & (drop_q == '0);
        discard_c      = imem_rsp_valid & ~FlushD & (drop_q != '0);
        InstrD         = ValidD ? instr_q[head_q] : NOP;
        PCD            = ValidD ? pc_q[head_q] : 32'h0;
        PCPlus4D       = PCD + 32'd4;
    end

    // Next-state: allocate at tail, fill oldest pending, pop head; flush clears all
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        fptr_d   = fptr_q;
        count_d  = count_q;
        pend_d   = pend_q;
        drop_d   = drop_q;
        filled_d = filled_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        if (FlushD) begin
            head_d   = tail_q;
            fptr_d   = tail_q;
            count_d  = '0;
            pend_d   = '0;
            filled_d = '0;
            drop_d   = drop_q + DW'(pend_q) - DW'(imem_rsp_valid);
        end else begin
            if (alloc_c) begin
                pc_d[tail_q] = PCF;
                tail_d       = tail_q + AW'(1);
            end
            if (fill_c) begin
                instr_d[fptr_q]  = imem_rsp_data;
                filled_d[fptr_q] = 1'b1;
                fptr_d           = fptr_q + AW'(1);
            end
            if (discard_c) begin
                drop_d = drop_q - DW'(1);
            end
            if (pop_c) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + AW'(1);
            end
            count_d = count_q + CW'(alloc_c) - CW'(pop_c);
            pend_d  = pend_q + CW'(alloc_c) - CW'(fill_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            fptr_q   <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            drop_q   <= '0;
            filled_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= NOP;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            fptr_q   <= fptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
            filled_q <= filled_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
        end
    end

endmodule
